eb_rr_arb: RTL

Round-robin arbiter that shares one elastic-buffer input channel between N upstream requesters using the req/ack handshake of the elastic-buffer family. It grants one requester at a time, forwards that requester's req to the shared channel, and returns the channel's ack. It drives the one-hot grant and binary select that steer the shared data mux in front of the buffer (e.g. an eb17 stage).

---
 rtl/eb_arb_pkg.sv | 13 +
 rtl/eb_rr_arb_if.sv | 25 ++
 rtl/eb_rr_pick.sv | 41 ++++
 rtl/eb_rr_arb.sv | 122 ++++++++++++
 4 files changed

// File: rtl/eb_arb_pkg.sv
// Shared types and reset constants for the elastic-buffer round-robin arbiter.
package eb_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int GNT_RST = 0;
  localparam int SEL_RST = 0;
  localparam int PTR_RST = 0;

endpackage

// File: rtl/eb_rr_arb_if.sv
// Requester-side and shared-channel handshake bundle for eb_rr_arb.
interface eb_rr_arb_if #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) ();

  logic [N-1:0]    t_req;
  logic [N-1:0]    t_last;
  logic [N-1:0]    t_ack;
  logic            i_0_req;
  logic            i_0_ack;
  logic [N-1:0]    gnt;
  logic [SELW-1:0] sel;

  modport master (
    input  t_req, t_last, i_0_ack,
    output t_ack, i_0_req, gnt, sel
  );

  modport slave (
    output t_req, t_last, i_0_ack,
    input  t_ack, i_0_req, gnt, sel
  );

endinterface

// File: rtl/eb_rr_pick.sv
// Rotating-priority search: first unmasked request at or above base,
// wrapping N-1 -> 0.
module eb_rr_pick #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] base,
  input  logic [N-1:0]    mask,
  output logic            found,
  output logic [SELW-1:0] idx,
  output logic [N-1:0]    onehot
);

  int              s;
  logic [SELW-1:0] k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    s     = 0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      s = int'(base) + i;
      if (s >= N) s = s - N;
      k = SELW'(s);
      if (!found && req[k] && !mask[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

  always_comb begin
    onehot = '0;
    for (int j = 0; j < N; j++) begin
      onehot[j] = found && (idx == SELW'(j));
    end
  end

endmodule

// File: rtl/eb_rr_arb.sv
// Round-robin arbiter sharing one elastic-buffer channel among N requesters.
// Define EB_RR_ARB_LOCK_EN to hold the grant for a whole t_last-delimited packet.
module eb_rr_arb
  import eb_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic        clk,
  input  logic        reset,
  eb_rr_arb_if.master bus
);

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            granted;
  logic            cur_req;
  logic            xfer;
  logic            rel;
  logic            pk_found;
  logic [SELW-1:0] pk_idx;
  logic [N-1:0]    pk_oh;
  logic [N-1:0]    pk_mask;

  assign granted = (state_q == GRANT);
  assign cur_req = bus.t_req[sel_q];
  assign xfer    = bus.i_0_req & bus.i_0_ack;

  assign bus.i_0_req = granted & cur_req;
  assign bus.t_ack   = granted ? (gnt_q & {N{bus.i_0_ack}}) : '0;
  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;

  // The owner is masked on release so a lone requester sees one idle cycle.
  assign pk_mask = granted ? gnt_q : '0;

  eb_rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req    (bus.t_req),
    .base   (ptr_q),
    .mask   (pk_mask),
    .found  (pk_found),
    .idx    (pk_idx),
    .onehot (pk_oh)
  );

`ifdef EB_RR_ARB_LOCK_EN
  logic in_pkt_q, in_pkt_d;
  logic last;

  assign last = bus.t_last[sel_q];
  assign rel  = (xfer & last) | (~cur_req & ~in_pkt_q);

  always_comb begin
    in_pkt_d = in_pkt_q;
    if (xfer) in_pkt_d = ~last;
  end

  always_ff @(posedge clk) begin
    if (reset) in_pkt_q <= 1'b0;
    else       in_pkt_q <= in_pkt_d;
  end
`else
  logic unused_t_last;

  assign unused_t_last = ^bus.t_last;
  assign rel           = xfer | ~cur_req;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pk_found) begin
          state_d = GRANT;
          gnt_d   = pk_oh;
          sel_d   = pk_idx;
          ptr_d   = (pk_idx == SELW'(N - 1)) ? '0 : pk_idx + SELW'(1);
        end
      end
      GRANT: begin
        if (rel) begin
          if (pk_found) begin
            gnt_d = pk_oh;
            sel_d = pk_idx;
            ptr_d = (pk_idx == SELW'(N - 1)) ? '0 : pk_idx + SELW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= N'(GNT_RST);
      sel_q   <= SELW'(SEL_RST);
      ptr_q   <= SELW'(PTR_RST);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
